// File: rtl/jtframe_bank_arb_pkg.sv
// Shared types for the SDRAM bank read arbiter and its channel picker.
package jtframe_bank_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Wide enough for any WDOG limit up to 255, independent of CH
  localparam int WDOG_CW = $clog2(256);

endpackage

// File: rtl/jtframe_bank_arb_pick.sv
// Combinational one-hot picker: fixed priority (RR=0, index 0 highest) or
// round-robin starting at ptr and wrapping modulo CH (RR=1).
module jtframe_bank_arb_pick #(
  parameter int CH = 4,
  parameter int RR = 1,
  localparam int PW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic [CH-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [CH-1:0] win,
  output logic          any
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < CH; i++) begin
      idx = (RR != 0) ? PW'((int'(ptr) + i) % CH) : PW'(i);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/jtframe_bank_arb.sv
// N-channel read arbiter sharing one jtframe_sdram64 bank port, one
// transaction in flight. Optional watchdog: JTFRAME_BANK_ARB_WDOG_EN.
module jtframe_bank_arb
  import jtframe_bank_arb_pkg::*;
#(
  parameter int CH   = 4,
  parameter int AW   = 22,
  parameter int DW   = 16,
  parameter int RR   = 1,
  parameter int WDOG = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH*AW-1:0]  ch_addr,
  input  logic [CH-1:0]     ch_rd,
  output logic [CH-1:0]     ch_ack,
  output logic [CH-1:0]     ch_dst,
  output logic [CH-1:0]     ch_dok,
  output logic [CH-1:0]     ch_rdy,
  output logic [DW-1:0]     ch_dout,
  output logic [AW-1:0]     ba_addr,
  output logic              ba_rd,
  input  logic              ba_ack,
  input  logic              ba_dst,
  input  logic              ba_dok,
  input  logic              ba_rdy,
  input  logic [DW-1:0]     ba_dout,
  output logic              busy,
  output logic              wdog_err
);

  localparam int PW = (CH > 1) ? $clog2(CH) : 1;

  state_t        state_q, state_d;
  logic [CH-1:0] gnt_q, gnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CH-1:0] win;
  logic          any;
  logic [PW-1:0] gnt_idx, ptr_next;
  logic          done, abort;

  jtframe_bank_arb_pick #(
    .CH (CH),
    .RR (RR)
  ) u_pick (
    .req (ch_rd),
    .ptr (ptr_q),
    .win (win),
    .any (any)
  );

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < CH; k++) begin
      if (gnt_q[k]) gnt_idx = PW'(k);
    end
  end

  assign ptr_next = (gnt_idx == PW'(CH - 1)) ? '0 : gnt_idx + PW'(1);

  // A same-cycle ack+rdy in REQ completes the transaction without visiting WAIT
  assign done = ((state_q == REQ) && ba_ack && ba_rdy) ||
                ((state_q == WAIT) && ba_rdy);

`ifdef JTFRAME_BANK_ARB_WDOG_EN
  logic [WDOG_CW-1:0] cnt_q, cnt_d;
  logic               wdog_err_q;

  assign cnt_d = (state_q == IDLE) ? '0 : cnt_q + WDOG_CW'(1);
  assign abort = (state_q != IDLE) && !done && (cnt_q == WDOG_CW'(WDOG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wdog_err_q <= abort;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign abort    = 1'b0;
  assign wdog_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = REQ;
          gnt_d   = win;
          for (int k = 0; k < CH; k++) begin
            if (win[k]) addr_d = ch_addr[k*AW +: AW];
          end
        end
      end
      REQ:     if (ba_ack) state_d = WAIT;
      WAIT:    state_d = WAIT;
      default: state_d = IDLE;
    endcase
    if (done || abort) begin
      state_d = IDLE;
      gnt_d   = '0;
      ptr_d   = ptr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign ba_rd   = (state_q == REQ);
  assign ba_addr = addr_q;
  assign ch_dout = ba_dout;

  // Strobes reach only the granted channel, and never while idle
  assign ch_ack = busy ? (gnt_q & {CH{ba_ack}}) : '0;
  assign ch_dst = busy ? (gnt_q & {CH{ba_dst}}) : '0;
  assign ch_dok = busy ? (gnt_q & {CH{ba_dok}}) : '0;
  assign ch_rdy = busy ? (gnt_q & {CH{ba_rdy}}) : '0;

endmodule

// File: tb/tb_jtframe_bank_arb.sv
// Directed bench for jtframe_bank_arb: one fixed-priority and one round-robin
// instance share stimulus; sel chooses which one is being checked.
module tb_jtframe_bank_arb;

  localparam int CH = 4;
  localparam int AW = 22;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CH*AW-1:0] ch_addr;
  logic [CH-1:0]    ch_rd;
  logic             ba_ack, ba_dst, ba_dok, ba_rdy;
  logic [DW-1:0]    ba_dout;

  logic [CH-1:0] aAck, aDst, aDok, aRdy, bAck, bDst, bDok, bRdy;
  logic [DW-1:0] aDout, bDout;
  logic [AW-1:0] aAddr, bAddr;
  logic          aRd, bRd, aBusy, bBusy, aWdog, bWdog;

  logic          sel;
  logic [CH-1:0] oAck, oDst, oDok, oRdy;
  logic [DW-1:0] oDout;
  logic [AW-1:0] oAddr;
  logic          oRd, oBusy, oWdog;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtframe_bank_arb #(.CH(CH), .AW(AW), .DW(DW), .RR(0), .WDOG(20)) u_fixed (
    .clk(clk), .rst_n(rst_n), .ch_addr(ch_addr), .ch_rd(ch_rd),
    .ch_ack(aAck), .ch_dst(aDst), .ch_dok(aDok), .ch_rdy(aRdy), .ch_dout(aDout),
    .ba_addr(aAddr), .ba_rd(aRd), .ba_ack(ba_ack), .ba_dst(ba_dst),
    .ba_dok(ba_dok), .ba_rdy(ba_rdy), .ba_dout(ba_dout),
    .busy(aBusy), .wdog_err(aWdog)
  );

  jtframe_bank_arb #(.CH(CH), .AW(AW), .DW(DW), .RR(1), .WDOG(20)) u_rr (
    .clk(clk), .rst_n(rst_n), .ch_addr(ch_addr), .ch_rd(ch_rd),
    .ch_ack(bAck), .ch_dst(bDst), .ch_dok(bDok), .ch_rdy(bRdy), .ch_dout(bDout),
    .ba_addr(bAddr), .ba_rd(bRd), .ba_ack(ba_ack), .ba_dst(ba_dst),
    .ba_dok(ba_dok), .ba_rdy(ba_rdy), .ba_dout(ba_dout),
    .busy(bBusy), .wdog_err(bWdog)
  );

  assign oAck  = sel ? bAck  : aAck;
  assign oDst  = sel ? bDst  : aDst;
  assign oDok  = sel ? bDok  : aDok;
  assign oRdy  = sel ? bRdy  : aRdy;
  assign oDout = sel ? bDout : aDout;
  assign oAddr = sel ? bAddr : aAddr;
  assign oRd   = sel ? bRd   : aRd;
  assign oBusy = sel ? bBusy : aBusy;
  assign oWdog = sel ? bWdog : aWdog;

  function automatic logic [AW-1:0] chAddr(input int k);
    chAddr = 22'h012340 + AW'(k * 32'h1111);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive this cycle's inputs just after the edge, then let them settle
  task automatic applyStimulus(input logic [CH-1:0] rd, input logic ack, input logic dst,
                               input logic dok, input logic rdy);
    @(posedge clk);
    #1;
    ch_rd  = rd;
    ba_ack = ack;
    ba_dst = dst;
    ba_dok = dok;
    ba_rdy = rdy;
    #1;
  endtask

  task automatic doReset();
    rst_n   = 1'b0;
    ch_rd   = '0;
    ba_ack  = 1'b0;
    ba_dst  = 1'b0;
    ba_dok  = 1'b0;
    ba_rdy  = 1'b0;
    ba_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < CH; k++) ch_addr[k*AW +: AW] = chAddr(k);
    sel = 1'b0;
    doReset();

    // Reset values
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checkOutput("rst_busy", 32'(oBusy), 32'd0);
      checkOutput("rst_ba_rd", 32'(oRd), 32'd0);
      checkOutput("rst_ba_addr", 32'(oAddr), 32'd0);
      checkOutput("rst_strobes", 32'({oAck, oDst, oDok, oRdy}), 32'd0);
      checkOutput("rst_wdog", 32'(oWdog), 32'd0);
    end

    // Fixed priority: channels 1 and 3 request together, 1 wins
    sel = 1'b0;
    applyStimulus(4'b1010, 0, 0, 0, 0);
    checkOutput("fp_idle_busy", 32'(oBusy), 32'd0);
    applyStimulus(4'b1010, 0, 0, 0, 0);
    checkOutput("fp_req_ba_rd", 32'(oRd), 32'd1);
    checkOutput("fp_addr1", 32'(oAddr), 32'(chAddr(1)));
    checkOutput("fp_no_ack_yet", 32'(oAck), 32'd0);
    applyStimulus(4'b1010, 1, 0, 0, 0);
    checkOutput("fp_ack1", 32'(oAck), 32'b0010);
    applyStimulus(4'b1000, 0, 0, 0, 0);
    checkOutput("fp_wait_ba_rd", 32'(oRd), 32'd0);
    checkOutput("fp_wait_busy", 32'(oBusy), 32'd1);
    applyStimulus(4'b1000, 0, 1, 0, 0);
    checkOutput("fp_dst1", 32'(oDst), 32'b0010);
    ba_dout = 16'h5A3C;
    applyStimulus(4'b1000, 0, 0, 1, 0);
    checkOutput("fp_dok1", 32'(oDok), 32'b0010);
    checkOutput("fp_dout1", 32'(oDout), 32'h5A3C);
    applyStimulus(4'b1000, 0, 0, 0, 1);
    checkOutput("fp_rdy1", 32'(oRdy), 32'b0010);
    applyStimulus(4'b1000, 0, 0, 0, 0);
    checkOutput("fp_bubble", 32'(oBusy), 32'd0);
    applyStimulus(4'b1000, 1, 0, 0, 0);
    checkOutput("fp_addr3", 32'(oAddr), 32'(chAddr(3)));
    checkOutput("fp_ack3", 32'(oAck), 32'b1000);
    applyStimulus(4'b0000, 0, 0, 0, 1);
    checkOutput("fp_rdy3", 32'(oRdy), 32'b1000);
    applyStimulus(4'b0000, 0, 0, 0, 0);
    checkOutput("fp_done_busy", 32'(oBusy), 32'd0);

    // Round robin: all channels held, order 0,1,2,3,0
    sel = 1'b1;
    doReset();
    applyStimulus(4'b1111, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 1, 0, 0, 0);
      checkOutput($sformatf("rr_addr_%0d", i), 32'(oAddr), 32'(chAddr(i % CH)));
      checkOutput($sformatf("rr_ack_%0d", i), 32'(oAck), 32'(4'b0001 << (i % CH)));
      applyStimulus(4'b1111, 0, 0, 0, 1);
      checkOutput($sformatf("rr_rdy_%0d", i), 32'(oRdy), 32'(4'b0001 << (i % CH)));
      applyStimulus(4'b1111, 0, 0, 0, 0);
      checkOutput($sformatf("rr_bubble_%0d", i), 32'(oBusy), 32'd0);
    end

    // Same-cycle ack and rdy: REQ straight back to IDLE
    sel = 1'b0;
    doReset();
    applyStimulus(4'b0001, 0, 0, 0, 0);
    applyStimulus(4'b0001, 1, 0, 0, 1);
    checkOutput("sc_ack", 32'(oAck), 32'b0001);
    checkOutput("sc_rdy", 32'(oRdy), 32'b0001);
    applyStimulus(4'b0001, 0, 0, 0, 0);
    checkOutput("sc_idle_busy", 32'(oBusy), 32'd0);
    checkOutput("sc_idle_ba_rd", 32'(oRd), 32'd0);
    applyStimulus(4'b0000, 1, 0, 0, 1);
    checkOutput("sc_regrant_ba_rd", 32'(oRd), 32'd1);
    applyStimulus(4'b0000, 0, 0, 0, 0);

    // Early drop: channel 2 releases its request before ack
    doReset();
    applyStimulus(4'b0100, 0, 0, 0, 0);
    applyStimulus(4'b0100, 0, 0, 0, 0);
    checkOutput("ed_ba_rd", 32'(oRd), 32'd1);
    applyStimulus(4'b0000, 0, 0, 0, 0);
    checkOutput("ed_ba_rd_held", 32'(oRd), 32'd1);
    applyStimulus(4'b0000, 1, 0, 0, 0);
    checkOutput("ed_ack", 32'(oAck), 32'b0100);
    ba_dout = 16'hBEEF;
    applyStimulus(4'b0000, 0, 0, 1, 0);
    checkOutput("ed_dok", 32'(oDok), 32'b0100);
    checkOutput("ed_dout", 32'(oDout), 32'hBEEF);
    applyStimulus(4'b0000, 0, 0, 0, 1);
    checkOutput("ed_rdy", 32'(oRdy), 32'b0100);
    applyStimulus(4'b0000, 0, 0, 0, 0);
    applyStimulus(4'b0000, 0, 0, 0, 0);
    checkOutput("ed_stays_idle", 32'(oBusy), 32'd0);

    // Reset in WAIT: pointer must return to 0 and a stray rdy is dropped
    sel = 1'b1;
    doReset();
    applyStimulus(4'b0010, 0, 0, 0, 0);
    applyStimulus(4'b0010, 1, 0, 0, 1);
    applyStimulus(4'b1000, 0, 0, 0, 0);
    applyStimulus(4'b1000, 1, 0, 0, 0);
    checkOutput("rw_ack3", 32'(oAck), 32'b1000);
    applyStimulus(4'b0000, 0, 0, 0, 0);
    checkOutput("rw_in_wait", 32'(oBusy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rw_async_busy", 32'(oBusy), 32'd0);
    checkOutput("rw_async_addr", 32'(oAddr), 32'd0);
    checkOutput("rw_async_ba_rd", 32'(oRd), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(4'b0000, 0, 0, 0, 1);
    checkOutput("rw_stray_rdy", 32'(oRdy), 32'd0);
    applyStimulus(4'b1111, 0, 0, 0, 0);
    applyStimulus(4'b1111, 1, 0, 0, 1);
    checkOutput("rw_ptr_zero", 32'(oAck), 32'b0001);
    applyStimulus(4'b0000, 0, 0, 0, 0);

    // Watchdog: bank never answers
    doReset();
    applyStimulus(4'b0011, 0, 0, 0, 0);
    applyStimulus(4'b0011, 0, 0, 0, 0);
    checkOutput("wd_granted", 32'(oBusy), 32'd1);
`ifdef JTFRAME_BANK_ARB_WDOG_EN
    repeat (19) applyStimulus(4'b0011, 0, 0, 0, 0);
    checkOutput("wd_before_busy", 32'(oBusy), 32'd1);
    checkOutput("wd_before_err", 32'(oWdog), 32'd0);
    applyStimulus(4'b0011, 0, 0, 0, 0);
    checkOutput("wd_err", 32'(oWdog), 32'd1);
    checkOutput("wd_ba_rd", 32'(oRd), 32'd0);
    checkOutput("wd_no_rdy", 32'(oRdy), 32'd0);
    applyStimulus(4'b0011, 0, 0, 0, 0);
    checkOutput("wd_err_pulse", 32'(oWdog), 32'd0);
    checkOutput("wd_next_addr", 32'(oAddr), 32'(chAddr(1)));
    checkOutput("wd_next_busy", 32'(oBusy), 32'd1);
`else
    repeat (40) applyStimulus(4'b0011, 0, 0, 0, 0);
    checkOutput("nowd_busy", 32'(oBusy), 32'd1);
    checkOutput("nowd_ba_rd", 32'(oRd), 32'd1);
    checkOutput("nowd_err", 32'(oWdog), 32'd0);
`endif
    doReset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
